// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one backing-memory port between Icache line refills
//               and Dcache line refills / write-backs. Whole-line bursts are
//               serialised. Round-robin arbitration; Dcache wins the first tie.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               i_req_i/i_addr_i           - Icache refill request
//               i_rdata_o/i_rvalid_o       - Icache refill beat data/strobe
//               i_done_o                   - Icache burst complete pulse
//               d_req_i/d_we_i/d_addr_i    - Dcache request, write flag, addr
//               d_wdata_i/d_beat_o         - write-back word for beat index
//               d_rdata_o/d_rvalid_o       - Dcache refill beat data/strobe
//               d_done_o                   - Dcache burst complete pulse
//               mem_*                      - memory beat port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_i,
  input  logic [ADDR_W-1:0]             i_addr_i,
  output logic [DATA_W-1:0]             i_rdata_o,
  output logic                          i_rvalid_o,
  output logic                          i_done_o,
  input  logic                          d_req_i,
  input  logic                          d_we_i,
  input  logic [ADDR_W-1:0]             d_addr_i,
  input  logic [DATA_W-1:0]             d_wdata_i,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat_o,
  output logic [DATA_W-1:0]             d_rdata_o,
  output logic                          d_rvalid_o,
  output logic                          d_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  input  logic                          mem_ready_i
);

  localparam int BEAT_W  = $clog2(LINE_WORDS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int LINE_SH = BEAT_W + BYTE_SH;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  // Clears the in-line offset bits so bursts always start at word 0.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_I_RD = 3'd1;
  localparam logic [2:0] S_D_RD = 3'd2;
  localparam logic [2:0] S_D_WR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  // 1 = Dcache received the most recent grant (round-robin pointer).
  logic              last_d_q, last_d_d;
  // 1 = Dcache owns the current (or just-finished) burst.
  logic              owner_d_q, owner_d_d;

  logic              w_d_wins;
  logic              w_burst;

  // Dcache takes the port if it is alone, or on a tie when Icache was last.
  assign w_d_wins = d_req_i & (~i_req_i | ~last_d_q);
  assign w_burst  = (state_q == S_I_RD) | (state_q == S_D_RD) |
                    (state_q == S_D_WR);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      last_d_q  <= 1'b0;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      last_d_q  <= last_d_d;
      owner_d_q <= owner_d_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    last_d_d  = last_d_q;
    owner_d_d = owner_d_q;
    case (state_q)
      S_IDLE: begin
        if (w_d_wins) begin
          state_d   = d_we_i ? S_D_WR : S_D_RD;
          base_d    = d_addr_i & LINE_MASK;
          last_d_d  = 1'b1;
          owner_d_d = 1'b1;
          beat_d    = '0;
        end else if (i_req_i) begin
          state_d   = S_I_RD;
          base_d    = i_addr_i & LINE_MASK;
          last_d_d  = 1'b0;
          owner_d_d = 1'b0;
          beat_d    = '0;
        end
      end
      S_I_RD, S_D_RD, S_D_WR: begin
        // Without ready the beat is a wait state and everything holds.
        if (mem_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = w_burst;
    mem_we_o    = (state_q == S_D_WR);
    mem_addr_o  = w_burst ? (base_q | (ADDR_W'(beat_q) << BYTE_SH)) : '0;
    mem_wdata_o = d_wdata_i;
    d_beat_o    = ((state_q == S_D_RD) | (state_q == S_D_WR)) ? beat_q : '0;
    i_rvalid_o  = (state_q == S_I_RD) & mem_ready_i;
    d_rvalid_o  = (state_q == S_D_RD) & mem_ready_i;
    i_rdata_o   = (state_q == S_I_RD) ? mem_rdata_i : '0;
    d_rdata_o   = (state_q == S_D_RD) ? mem_rdata_i : '0;
    i_done_o    = (state_q == S_DONE) & ~owner_d_q;
    d_done_o    = (state_q == S_DONE) & owner_d_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench for mem_bus_arbiter. Stimulus pushes the
//               expected beat/done sequence; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic [31:0] i_rdata_o;
  logic        i_rvalid_o;
  logic        i_done_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_beat_o;
  logic [31:0] d_rdata_o;
  logic        d_rvalid_o;
  logic        d_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  logic        ready_every2 = 1'b0;
  logic        tog = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata_i = mem_model(mem_addr_o);
  assign d_wdata_i   = 32'hD00D_0000 | 32'(d_beat_o);
  assign mem_ready_i = ~ready_every2 | tog;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tog <= ~tog;
    cyc <= cyc + 1;
  end

  mem_bus_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_rdata_o   (i_rdata_o),
    .i_rvalid_o  (i_rvalid_o),
    .i_done_o    (i_done_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_beat_o    (d_beat_o),
    .d_rdata_o   (d_rdata_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_done_o    (d_done_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  typedef struct {
    bit          done;
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          beat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beat_cnt = 0;
  int   last_done_cyc = -100;
  int   gap_at_start  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_burst(input bit d, input bit we, input logic [31:0] addr,
                            input int nbeats, input bit with_done);
    exp_t        e;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int b = 0; b < nbeats; b++) begin
      e.done = 1'b0;
      e.d    = d;
      e.we   = we;
      e.addr = base + 32'(4 * b);
      e.beat = b;
      e.data = we ? (32'hD00D_0000 | 32'(b)) : mem_model(e.addr);
      sb.push_back(e);
    end
    if (with_done) begin
      e.done = 1'b1;
      e.d    = d;
      e.we   = we;
      e.addr = '0;
      e.data = '0;
      e.beat = 0;
      sb.push_back(e);
    end
  endtask

  // Waits for the owner's done pulse; optionally drops its request in the
  // done cycle. Returns the cycle number of the done pulse.
  task automatic wait_done(input bit is_d, input bit drop, output int t);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    t = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (is_d ? d_done_o : i_done_o) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    chk(is_d ? "d_done_seen" : "i_done_seen", 32'(seen), 32'd1);
    if (seen && drop) begin
      if (is_d) d_req_i = 1'b0;
      else      i_req_i = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  bit          prev_wait = 1'b0;
  bit          prev_req  = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_we;

  always @(negedge clk) begin
    exp_t e;
    int   n_hi;
    if (!rst_n) begin
      prev_wait = 1'b0;
      prev_req  = 1'b0;
    end else begin
      n_hi = int'(i_rvalid_o) + int'(d_rvalid_o) + int'(i_done_o) + int'(d_done_o);
      if (n_hi != 0) chk("one_hot_strobes", 32'(n_hi), 32'd1);
      if (prev_wait && mem_req_o) begin
        chk("wait_addr_hold", mem_addr_o, prev_addr);
        chk("wait_we_hold", 32'(mem_we_o), 32'(prev_we));
        if (prev_we) chk("wait_wdata_hold", mem_wdata_o, prev_wdata);
      end
      if (mem_req_o && !prev_req) gap_at_start = cyc - last_done_cyc;
      if (mem_req_o && mem_ready_i) begin
        if (sb.size() == 0 || sb[0].done) begin
          chk("unexpected_beat", mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          beat_cnt++;
          chk("beat_addr", mem_addr_o, e.addr);
          chk("beat_we", 32'(mem_we_o), 32'(e.we));
          chk("d_beat", 32'(d_beat_o), e.d ? 32'(e.beat) : 32'd0);
          if (e.we) begin
            chk("wdata", mem_wdata_o, e.data);
            chk("d_rvalid_on_write", 32'(d_rvalid_o), 32'd0);
          end else if (e.d) begin
            chk("d_rvalid", 32'(d_rvalid_o), 32'd1);
            chk("d_rdata", d_rdata_o, e.data);
          end else begin
            chk("i_rvalid", 32'(i_rvalid_o), 32'd1);
            chk("i_rdata", i_rdata_o, e.data);
          end
        end
      end
      if (i_done_o || d_done_o) begin
        if (sb.size() == 0 || !sb[0].done) begin
          chk("unexpected_done", 32'({i_done_o, d_done_o}), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_owner_d", 32'(d_done_o), 32'(e.d));
        end
        last_done_cyc = cyc;
      end
      prev_wait  = mem_req_o && !mem_ready_i;
      prev_req   = mem_req_o;
      prev_addr  = mem_addr_o;
      prev_we    = mem_we_o;
      prev_wdata = mem_wdata_o;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int t;
    int t0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_rvalid", 32'({i_rvalid_o, d_rvalid_o}), 32'd0);
    chk("rst_done", 32'({i_done_o, d_done_o}), 32'd0);
    chk("rst_d_beat", 32'(d_beat_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Tie: Dcache wins first, then Icache after one DONE + one IDLE cycle
    push_burst(1'b1, 1'b0, 32'h0000_4008, 4, 1'b1);
    push_burst(1'b0, 1'b0, 32'h0000_5004, 4, 1'b1);
    d_we_i = 1'b0; d_addr_i = 32'h0000_4008; i_addr_i = 32'h0000_5004;
    d_req_i = 1'b1; i_req_i = 1'b1;
    wait_done(1'b1, 1'b1, t);
    wait_done(1'b0, 1'b1, t);
    chk("tie_gap", 32'(gap_at_start), 32'd2);

    // Icache read, ready always, done five cycles after request
    repeat (2) @(negedge clk);
    push_burst(1'b0, 1'b0, 32'h0000_1008, 4, 1'b1);
    i_addr_i = 32'h0000_1008;
    t0 = cyc;
    i_req_i = 1'b1;
    wait_done(1'b0, 1'b1, t);
    chk("i_latency", 32'(t - t0), 32'd5);

    // Dcache write-back with ready every second cycle
    repeat (2) @(negedge clk);
    ready_every2 = 1'b1;
    push_burst(1'b1, 1'b1, 32'h0000_2010, 4, 1'b1);
    d_we_i = 1'b1; d_addr_i = 32'h0000_2010;
    d_req_i = 1'b1;
    wait_done(1'b1, 1'b1, t);
    ready_every2 = 1'b0;

    // Back-to-back Dcache with Icache pending: D, I, D
    repeat (2) @(negedge clk);
    push_burst(1'b1, 1'b0, 32'h0000_7000, 4, 1'b1);
    push_burst(1'b0, 1'b0, 32'h0000_8000, 4, 1'b1);
    push_burst(1'b1, 1'b0, 32'h0000_9030, 4, 1'b1);
    d_we_i = 1'b0; d_addr_i = 32'h0000_7000;
    d_req_i = 1'b1;
    @(negedge clk);
    i_addr_i = 32'h0000_8000;
    i_req_i = 1'b1;
    wait_done(1'b1, 1'b0, t);
    d_addr_i = 32'h0000_9030;
    wait_done(1'b0, 1'b1, t);
    wait_done(1'b1, 1'b1, t);

    // Icache drops request after beat 1: burst still completes
    repeat (2) @(negedge clk);
    push_burst(1'b0, 1'b0, 32'h0000_6000, 4, 1'b1);
    i_addr_i = 32'h0000_600C;
    n = beat_cnt;
    i_req_i = 1'b1;
    t0 = 0;
    while (beat_cnt < n + 2 && t0 < 50) begin
      @(negedge clk);
      t0++;
    end
    i_req_i = 1'b0;
    wait_done(1'b0, 1'b0, t);

    // Reset during beat 2 of a Dcache refill
    repeat (2) @(negedge clk);
    push_burst(1'b1, 1'b0, 32'h0000_300C, 2, 1'b0);
    d_we_i = 1'b0; d_addr_i = 32'h0000_300C;
    d_req_i = 1'b1;
    t0 = 0;
    while (!(mem_req_o && d_beat_o == 2'd2) && t0 < 50) begin
      @(posedge clk);
      #1;
      t0++;
    end
    rst_n = 1'b0;
    d_req_i = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
    chk("midrst_d_beat", 32'(d_beat_o), 32'd0);
    chk("midrst_done", 32'({i_done_o, d_done_o}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_idle", 32'(mem_req_o), 32'd0);

    // Fresh request after reset starts from beat 0
    push_burst(1'b1, 1'b0, 32'h0000_3024, 4, 1'b1);
    d_addr_i = 32'h0000_3024;
    d_req_i = 1'b1;
    wait_done(1'b1, 1'b1, t);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
